// File: rtl/mem_bus_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter_if
//
// Purpose:
//   Bundles the two requester handshakes (port 0 = MIPS CPU, port 1 = program
//   loader / debug) and the MemoryB control lines (CS/WE/Address) that the
//   arbiter drives. The bidirectional Mem_Bus data line is kept as a plain
//   inout on the arbiter so the tri-state driver stays at module level.
//
// Handshake (both ports):
//   pN_req acts as "valid". Once raised, the requester keeps pN_req, pN_we,
//   pN_addr, pN_wdata stable until it sees the single-cycle pN_done pulse; the
//   done pulse is the only "ready/accepted+completed" indication. After a read,
//   pN_rdata is valid in the pN_done cycle and holds until the next read done
//   on that port. The requester may present its next transaction (or drop
//   req) in the cycle right after pN_done.
//
// Signals:
//   pN_req / pN_we / pN_addr / pN_wdata / pN_lock   requester -> arbiter
//   pN_done / pN_rdata                              arbiter   -> requester
//   Mem_CS / Mem_WE / Mem_Addr                      arbiter   -> MemoryB
//
// Modports:
//   master : requester side (drives requests, observes completions/memory)
//   slave  : arbiter side
// -----------------------------------------------------------------------------
interface mem_bus_arbiter_if #(
   parameter int AW = 7,
   parameter int DW = 32
) ();

   logic          p0_req;
   logic          p0_we;
   logic [AW-1:0] p0_addr;
   logic [DW-1:0] p0_wdata;
   logic          p0_lock;
   logic          p0_done;
   logic [DW-1:0] p0_rdata;

   logic          p1_req;
   logic          p1_we;
   logic [AW-1:0] p1_addr;
   logic [DW-1:0] p1_wdata;
   logic          p1_lock;
   logic          p1_done;
   logic [DW-1:0] p1_rdata;

   logic          Mem_CS;
   logic          Mem_WE;
   logic [AW-1:0] Mem_Addr;

   modport master (
      output p0_req, p0_we, p0_addr, p0_wdata, p0_lock,
      output p1_req, p1_we, p1_addr, p1_wdata, p1_lock,
      input  p0_done, p0_rdata,
      input  p1_done, p1_rdata,
      input  Mem_CS, Mem_WE, Mem_Addr
   );

   modport slave (
      input  p0_req, p0_we, p0_addr, p0_wdata, p0_lock,
      input  p1_req, p1_we, p1_addr, p1_wdata, p1_lock,
      output p0_done, p0_rdata,
      output p1_done, p1_rdata,
      output Mem_CS, Mem_WE, Mem_Addr
   );

endinterface

// File: rtl/mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter
//
// Purpose:
//   Shares the single-port MemoryB between port 0 (MIPS CPU) and port 1
//   (program loader / debug). Each access is sequenced through a small FSM,
//   the shared data bus is driven only while writing, read data is captured
//   per port, and simultaneous requests are resolved round-robin.
//
// Ports:
//   CLK          in     clock, everything on the rising edge
//   rst          in     synchronous reset, active-low
//   bus          slave  requester handshakes + Mem_CS/Mem_WE/Mem_Addr
//   Mem_Bus      inout  shared 32-bit data bus, driven only in the WR state
//   o_dbg_state  out    current FSM state (IDLE=0, WR=1, RD=2, RDCAP=3)
//
// Timing (k = edge at which the request is granted):
//   write : WR state in the cycle after edge k, done in that same cycle
//   read  : RD after edge k, RDCAP after edge k+1 with done + rdata
//   every access returns to IDLE for one cycle (write 2 cycles, read 3).
//
// Configuration:
//   ARB_LOCK_EN  when defined, an owner holding pN_lock=1 with pN_req=1 in the
//                IDLE cycle after its access is re-granted regardless of the
//                other port. When undefined, pN_lock is ignored.
// -----------------------------------------------------------------------------
module mem_bus_arbiter #(
   parameter int AW = 7,
   parameter int DW = 32
) (
   input  logic                  CLK,
   input  logic                  rst,
   mem_bus_arbiter_if.slave      bus,
   inout  wire  [DW-1:0]         Mem_Bus,
   output logic [1:0]            o_dbg_state
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_WR    = 2'd1;
   localparam logic [1:0] S_RD    = 2'd2;
   localparam logic [1:0] S_RDCAP = 2'd3;

   // ---------------------------------------------------------------------------
   // State and registered outputs
   // ---------------------------------------------------------------------------
   logic [1:0]    r_state;
   logic          r_sel;        // port served by the access in flight
   logic          r_last;       // last granted port; reset value 1 favours port 0
   logic          r_owner_vld;  // r_last still owns the bus for lock purposes
   logic          r_cs;
   logic          r_mem_we;
   logic [AW-1:0] r_addr;
   logic          r_bus_oe;
   logic [DW-1:0] r_bus_data;
   logic          r_done0;
   logic          r_done1;
   logic [DW-1:0] r_rdata0;
   logic [DW-1:0] r_rdata1;

   // ---------------------------------------------------------------------------
   // Arbitration (evaluated only while IDLE)
   // ---------------------------------------------------------------------------
   logic          w_grant;
   logic          w_gsel;
   logic          w_lock_hold;
   logic          w_g_we;
   logic [AW-1:0] w_g_addr;
   logic [DW-1:0] w_g_wdata;

`ifdef ARB_LOCK_EN
   // The previous owner keeps the bus while it still asks for it with lock set.
   assign w_lock_hold = r_owner_vld &&
                        (r_last ? (bus.p1_req && bus.p1_lock)
                                : (bus.p0_req && bus.p0_lock));
`else
   logic w_unused_lock;
   assign w_lock_hold   = 1'b0;
   assign w_unused_lock = bus.p0_lock ^ bus.p1_lock ^ r_owner_vld;
`endif

   always_comb begin
      w_grant = 1'b0;
      w_gsel  = 1'b0;
      if (w_lock_hold) begin
         w_grant = 1'b1;
         w_gsel  = r_last;
      end else if (bus.p0_req && bus.p1_req) begin
         // Both waiting: serve the port that was not served last.
         w_grant = 1'b1;
         w_gsel  = ~r_last;
      end else if (bus.p0_req) begin
         w_grant = 1'b1;
         w_gsel  = 1'b0;
      end else if (bus.p1_req) begin
         w_grant = 1'b1;
         w_gsel  = 1'b1;
      end
   end

   assign w_g_we    = w_gsel ? bus.p1_we    : bus.p0_we;
   assign w_g_addr  = w_gsel ? bus.p1_addr  : bus.p0_addr;
   assign w_g_wdata = w_gsel ? bus.p1_wdata : bus.p0_wdata;

   // ---------------------------------------------------------------------------
   // Access sequencer
   // ---------------------------------------------------------------------------
   always_ff @(posedge CLK) begin
      if (!rst) begin
         r_state     <= S_IDLE;
         r_sel       <= 1'b0;
         r_last      <= 1'b1;
         r_owner_vld <= 1'b0;
         r_cs        <= 1'b0;
         r_mem_we    <= 1'b0;
         r_addr      <= '0;
         r_bus_oe    <= 1'b0;
         r_bus_data  <= '0;
         r_done0     <= 1'b0;
         r_done1     <= 1'b0;
         r_rdata0    <= '0;
         r_rdata1    <= '0;
      end else begin
         // done is a single-cycle pulse unless set again below
         r_done0 <= 1'b0;
         r_done1 <= 1'b0;

         case (r_state)
            S_IDLE: begin
               if (w_grant) begin
                  r_sel       <= w_gsel;
                  r_last      <= w_gsel;
                  r_owner_vld <= 1'b1;
                  r_cs        <= 1'b1;
                  r_mem_we    <= w_g_we;
                  r_addr      <= w_g_addr;
                  if (w_g_we) begin
                     // Write completes in the WR cycle itself, so done and
                     // the bus drive are launched together with CS/WE.
                     r_state    <= S_WR;
                     r_bus_oe   <= 1'b1;
                     r_bus_data <= w_g_wdata;
                     r_done0    <= ~w_gsel;
                     r_done1    <= w_gsel;
                  end else begin
                     r_state    <= S_RD;
                  end
               end else begin
                  // Nobody asking: any lock is released.
                  r_owner_vld <= 1'b0;
               end
            end

            S_WR: begin
               // MemoryB commits on this edge; WE and the bus drop together.
               r_state  <= S_IDLE;
               r_cs     <= 1'b0;
               r_mem_we <= 1'b0;
               r_bus_oe <= 1'b0;
            end

            S_RD: begin
               // MemoryB has driven the addressed word during RD; capture it
               // here so rdata and done appear together in the RDCAP cycle.
               r_state <= S_RDCAP;
               if (r_sel) begin
                  r_rdata1 <= Mem_Bus;
                  r_done1  <= 1'b1;
               end else begin
                  r_rdata0 <= Mem_Bus;
                  r_done0  <= 1'b1;
               end
            end

            S_RDCAP: begin
               r_state  <= S_IDLE;
               r_cs     <= 1'b0;
               r_mem_we <= 1'b0;
            end

            default: begin
               r_state  <= S_IDLE;
               r_cs     <= 1'b0;
               r_mem_we <= 1'b0;
               r_bus_oe <= 1'b0;
            end
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   assign bus.Mem_CS   = r_cs;
   assign bus.Mem_WE   = r_mem_we;
   assign bus.Mem_Addr = r_addr;
   assign bus.p0_done  = r_done0;
   assign bus.p1_done  = r_done1;
   assign bus.p0_rdata = r_rdata0;
   assign bus.p1_rdata = r_rdata1;

   assign Mem_Bus      = r_bus_oe ? r_bus_data : {DW{1'bz}};

   assign o_dbg_state  = r_state;

endmodule
